// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command sequencer and the bank/row
// terminator that consumes its CMD tracking bus.
//   - CMD tracking codes (must match the terminator bit for bit)
//   - SDRAM command pin encodings {nCS, nRAS, nCAS, nWE}
//   - CPU address slice positions for row, column and bank
//   - sequencer state type and the mode-register helper
package sdram_pkg;

    // CMD tracking codes. 101 and 111 are never driven.
    localparam logic [2:0] CMD_RESET = 3'b000;
    localparam logic [2:0] CMD_ACT   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_PALL  = 3'b011;
    localparam logic [2:0] CMD_NOP   = 3'b100;
    localparam logic [2:0] CMD_CLR   = 3'b110;

    // SDRAM pin encodings {nCS, nRAS, nCAS, nWE}
    localparam logic [3:0] SD_NOP   = 4'b0111;
    localparam logic [3:0] SD_ACT   = 4'b0011;
    localparam logic [3:0] SD_READ  = 4'b0101;
    localparam logic [3:0] SD_WRITE = 4'b0100;
    localparam logic [3:0] SD_PRE   = 4'b0010;
    localparam logic [3:0] SD_REF   = 4'b0001;
    localparam logic [3:0] SD_MRS   = 4'b0000;

    // A10 high selects all banks on PRECHARGE
    localparam logic [12:0] RA_ALL_BANKS = 13'h0400;

    // CPU address slices (byte-address bit numbers)
    localparam int ROW_MSB  = 25;
    localparam int ROW_LSB  = 13;
    localparam int COL_MSB  = 12;
    localparam int COL_LSB  = 4;
    localparam int BANK_MSB = 3;
    localparam int BANK_LSB = 2;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PALL,
        S_INIT_REF,
        S_INIT_MRS,
        S_IDLE,
        S_PRE_WAIT,
        S_ACT_WAIT,
        S_RD_WAIT,
        S_DONE,
        S_RF_PALL,
        S_RF_WAIT
    } state_e;

    // Burst length 1, sequential, CAS latency in [6:4]. With a burst of one
    // the write-burst-mode bit has no effect, so it is left at 0.
    function automatic logic [12:0] mode_reg(input int cl);
        return 13'((cl & 7) << 4);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   en_i   : count enable; while low the counter is held at its reload value
//            and no refresh is pending (used during initialisation)
//   clr_i  : the sequencer has started servicing the pending refresh
//   req_o  : refresh wanted (pending flag, or expiry in this very cycle so a
//            same-cycle access request loses to it)
module sdram_refresh_timer #(
    parameter int REFI = 780
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic req_o
);
    localparam int CW = $clog2(REFI);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          expire;

    assign expire = en_i && (cnt_q == '0);
    assign req_o  = pend_q | expire;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (!en_i) begin
            cnt_d  = CW'(REFI - 1);
            pend_d = 1'b0;
        end else if (expire) begin
            cnt_d  = CW'(REFI - 1);
            // A clear issued for an older request leaves this expiry pending;
            // a clear issued for this expiry itself consumes it.
            pend_d = pend_q | ~clr_i;
        end else begin
            cnt_d  = cnt_q - CW'(1);
            pend_d = pend_q & ~clr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= CW'(REFI - 1);
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/sdram_cmd_seq.sv
// SDRAM command sequencer for the main-RAM window (A[31]=0), open-row policy.
//   CLK, RESET            : clock, synchronous active-high reset
//   A[31:2], nWE, SEL     : CPU access (SEL held until termination)
//   STERMout              : slow-path termination pulse to the terminator
//   CMD[2:0]              : tracking code for the bank/row terminator
//   nRCS/nRRAS/nRCAS/nRWE : SDRAM command pins
//   RBA, RA               : SDRAM bank and address
//   dbg_state_o           : current sequencer state
// Handshake: SEL acts as "valid" and is held with a stable A/nWE until the
// access terminates (STERMout here, or the terminator for write hits). A new
// access is accepted only after SEL has been seen low following termination.
// All outputs are registered: a decision taken at an edge appears on the
// pins in the cycle that follows it.
module sdram_cmd_seq
    import sdram_pkg::*;
#(
    parameter int tRP       = 2,
    parameter int tRCD      = 2,
    parameter int CL        = 2,
    parameter int tRFC      = 7,
    parameter int REFI      = 780,
    parameter int INIT_WAIT = 5000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:2] A,
    input  logic        nWE,
    input  logic        SEL,
    output logic        STERMout,
    output logic [2:0]  CMD,
    output logic        nRCS,
    output logic        nRRAS,
    output logic        nRCAS,
    output logic        nRWE,
    output logic [1:0]  RBA,
    output logic [12:0] RA,
    output state_e      dbg_state_o
);
    localparam int IW = $clog2(INIT_WAIT + 1);

    state_e            state_q, state_d;
    logic [3:0]        tmr_q, tmr_d;
    logic [IW-1:0]     init_q, init_d;
    logic [2:0]        refn_q, refn_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [3:0]        pins_q, pins_d;
    logic [12:0]       ra_q, ra_d;
    logic [1:0]        rba_q, rba_d;
    logic              sterm_q, sterm_d;
    logic [3:0]        open_q;
    logic [3:0][12:0]  row_q;

    logic              sel_ok, hit, ref_req, ref_clr, timer_en;
    logic              do_act, do_rw, rw_slow, unused_addr;
    logic [12:0]       row_a;
    logic [8:0]        col_a;
    logic [1:0]        bank_a;

    assign row_a       = A[ROW_MSB:ROW_LSB];
    assign col_a       = A[COL_MSB:COL_LSB];
    assign bank_a      = A[BANK_MSB:BANK_LSB];
    assign unused_addr = ^A[30:26];
    assign sel_ok      = SEL && !A[31];
    assign hit         = open_q[bank_a] && (row_q[bank_a] == row_a);
    assign timer_en    = !(state_q inside {S_INIT_WAIT, S_INIT_PALL, S_INIT_REF, S_INIT_MRS});

    sdram_refresh_timer #(.REFI(REFI)) u_refresh (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (timer_en),
        .clr_i (ref_clr),
        .req_o (ref_req)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = (tmr_q != 4'd0) ? tmr_q - 4'd1 : 4'd0;
        init_d  = init_q;
        refn_d  = refn_q;
        cmd_d   = CMD_NOP;
        pins_d  = SD_NOP;
        ra_d    = '0;
        rba_d   = '0;
        sterm_d = 1'b0;
        ref_clr = 1'b0;
        do_act  = 1'b0;
        do_rw   = 1'b0;
        rw_slow = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                cmd_d = CMD_RESET;
                if (init_q == IW'(INIT_WAIT - 1)) begin
                    cmd_d   = CMD_PALL;
                    pins_d  = SD_PRE;
                    ra_d    = RA_ALL_BANKS;
                    tmr_d   = 4'(tRP - 1);
                    state_d = S_INIT_PALL;
                end else begin
                    init_d = init_q + IW'(1);
                end
            end
            S_INIT_PALL: if (tmr_q == 4'd0) begin
                pins_d  = SD_REF;
                tmr_d   = 4'(tRFC - 1);
                refn_d  = 3'd0;
                state_d = S_INIT_REF;
            end
            S_INIT_REF: if (tmr_q == 4'd0) begin
                if (refn_q == 3'd7) begin
                    pins_d  = SD_MRS;
                    ra_d    = mode_reg(CL);
                    tmr_d   = 4'd1;   // tMRD of two cycles
                    state_d = S_INIT_MRS;
                end else begin
                    pins_d = SD_REF;
                    tmr_d  = 4'(tRFC - 1);
                    refn_d = refn_q + 3'd1;
                end
            end
            S_INIT_MRS: if (tmr_q == 4'd0) state_d = S_IDLE;
            S_IDLE: begin
                if (ref_req) begin
                    cmd_d   = CMD_PALL;
                    pins_d  = SD_PRE;
                    ra_d    = RA_ALL_BANKS;
                    tmr_d   = 4'(tRP - 1);
                    ref_clr = 1'b1;
                    state_d = S_RF_PALL;
                end else if (sel_ok) begin
                    if (hit) begin
                        do_rw = 1'b1;
                    end else if (open_q[bank_a]) begin
                        cmd_d   = CMD_PRE;
                        pins_d  = SD_PRE;
                        rba_d   = bank_a;
                        tmr_d   = 4'(tRP - 1);
                        state_d = S_PRE_WAIT;
                    end else begin
                        do_act = 1'b1;
                    end
                end
            end
            // Aborted accesses finish their wait, then drop back to IDLE.
            S_PRE_WAIT: if (tmr_q == 4'd0) begin
                if (sel_ok) do_act = 1'b1;
                else        state_d = S_IDLE;
            end
            S_ACT_WAIT: if (tmr_q == 4'd0) begin
                if (sel_ok) begin
                    do_rw   = 1'b1;
                    rw_slow = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: if (tmr_q == 4'd0) begin
                sterm_d = sel_ok;
                state_d = sel_ok ? S_DONE : S_IDLE;
            end
            S_DONE: if (!SEL) state_d = S_IDLE;
            S_RF_PALL: if (tmr_q == 4'd0) begin
                pins_d  = SD_REF;
                tmr_d   = 4'(tRFC - 1);
                state_d = S_RF_WAIT;
            end
            S_RF_WAIT: if (tmr_q == 4'd0) begin
                cmd_d   = CMD_CLR;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_WAIT;
        endcase

        if (do_act) begin
            cmd_d   = CMD_ACT;
            pins_d  = SD_ACT;
            ra_d    = row_a;
            rba_d   = bank_a;
            tmr_d   = 4'(tRCD - 1);
            state_d = S_ACT_WAIT;
        end
        if (do_rw) begin
            ra_d  = {4'b0000, col_a};
            rba_d = bank_a;
            if (nWE) begin
                pins_d  = SD_READ;
                tmr_d   = 4'(CL - 1);
                state_d = S_RD_WAIT;
            end else begin
                // Write hits are terminated by the terminator; writes that
                // needed an activate are terminated here.
                pins_d  = SD_WRITE;
                cmd_d   = CMD_CLR;
                sterm_d = rw_slow;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_INIT_WAIT;
            tmr_q   <= 4'd0;
            init_q  <= '0;
            refn_q  <= 3'd0;
            cmd_q   <= CMD_RESET;
            pins_q  <= SD_NOP;
            ra_q    <= '0;
            rba_q   <= '0;
            sterm_q <= 1'b0;
            open_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            init_q  <= init_d;
            refn_q  <= refn_d;
            cmd_q   <= cmd_d;
            pins_q  <= pins_d;
            ra_q    <= ra_d;
            rba_q   <= rba_d;
            sterm_q <= sterm_d;
            // Shadow follows the CMD bus exactly as the terminator does.
            case (cmd_d)
                CMD_ACT: begin
                    open_q[rba_d] <= 1'b1;
                    row_q[rba_d]  <= ra_d;
                end
                CMD_PRE:             open_q[rba_d] <= 1'b0;
                CMD_PALL, CMD_RESET: open_q        <= '0;
                default: ;
            endcase
        end
    end

    assign CMD         = cmd_q;
    assign {nRCS, nRRAS, nRCAS, nRWE} = pins_q;
    assign RA          = ra_q;
    assign RBA         = rba_q;
    assign STERMout    = sterm_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Directed bench for sdram_cmd_seq: init sequence, a table of access steps
// with hand-computed per-cycle outputs, then refresh collision and a reset
// during the activate wait.
module tb_sdram_cmd_seq;
    import sdram_pkg::*;

    localparam int INIT_W = 20;
    localparam int REFI_T = 200;

    localparam logic [3:0] P_NOP = 4'b0111, P_ACT = 4'b0011, P_RD  = 4'b0101;
    localparam logic [3:0] P_WR  = 4'b0100, P_PRE = 4'b0010, P_REF = 4'b0001;
    localparam logic [3:0] P_MRS = 4'b0000;
    localparam logic [2:0] C_RST = 3'b000, C_ACT = 3'b001, C_PRE = 3'b010;
    localparam logic [2:0] C_PALL = 3'b011, C_NOP = 3'b100, C_CLR = 3'b110;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        nwe = 1'b1;
    logic        sel = 1'b0;
    logic        sterm, ncs, nras, ncas, nwe_o;
    logic [2:0]  cmd;
    logic [1:0]  rba;
    logic [12:0] ra;
    state_e      dbg;

    sdram_cmd_seq #(
        .tRP(2), .tRCD(2), .CL(2), .tRFC(7), .REFI(REFI_T), .INIT_WAIT(INIT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .A(addr[31:2]), .nWE(nwe), .SEL(sel),
        .STERMout(sterm), .CMD(cmd), .nRCS(ncs), .nRRAS(nras), .nRCAS(ncas),
        .nRWE(nwe_o), .RBA(rba), .RA(ra), .dbg_state_o(dbg)
    );

    // clock / reset block
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [3:0]  pins;
        logic [12:0] ra;
        logic [1:0]  rba;
        logic        st;
    } obs_t;

    typedef struct {
        logic        start;
        logic [31:0] a;
        logic        w_n;
        logic        drop;
        obs_t        exp;
    } step_t;

    step_t steps[$];

    function automatic obs_t mk(logic [2:0] c, logic [3:0] p, logic [12:0] r,
                                logic [1:0] b, logic s);
        obs_t o;
        o.cmd = c; o.pins = p; o.ra = r; o.rba = b; o.st = s;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(cmd, {ncs, nras, ncas, nwe_o}, ra, rba, sterm);
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cmd=%b pins=%b ra=%h rba=%0d st=%b, need cmd=%b pins=%b ra=%h rba=%0d st=%b",
                     name, act.cmd, act.pins, act.ra, act.rba, act.st,
                     exp.cmd, exp.pins, exp.ra, exp.rba, exp.st);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    // driver helpers
    task automatic add(input logic s, input logic [31:0] a, input logic w_n,
                       input logic d, input obs_t e);
        step_t t;
        t.start = s; t.a = a; t.w_n = w_n; t.drop = d; t.exp = e;
        steps.push_back(t);
    endtask

    task automatic nop_step(input logic d, input logic st);
        add(1'b0, 32'h0, 1'b1, d, mk(C_NOP, P_NOP, 13'h0, 2'd0, st));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin : main
        int bad, nref, last, gap, others, mrs_seen, mrs_ra, mrs_gap, idle0, target;

        // T1 cold read 0x2004: row 1, bank 1, col 0
        add(1'b1, 32'h0000_2004, 1'b1, 1'b0, mk(C_ACT, P_ACT, 13'h1, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 1'b0, mk(C_NOP, P_RD, 13'h0, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        nop_step(1'b1, 1'b1);
        nop_step(1'b0, 1'b0);
        // T2 write hit 0x2014: col 1
        add(1'b1, 32'h0000_2014, 1'b0, 1'b1, mk(C_CLR, P_WR, 13'h1, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        // T3 row conflict read 0x4004: row 2, bank 1
        add(1'b1, 32'h0000_4004, 1'b1, 1'b0, mk(C_PRE, P_PRE, 13'h0, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 1'b0, mk(C_ACT, P_ACT, 13'h2, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 1'b0, mk(C_NOP, P_RD, 13'h0, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        nop_step(1'b1, 1'b1);
        nop_step(1'b0, 1'b0);
        // T4 read hit 0x4014 proves bank 1 now holds row 2
        add(1'b1, 32'h0000_4014, 1'b1, 1'b0, mk(C_NOP, P_RD, 13'h1, 2'd1, 1'b0));
        nop_step(1'b0, 1'b0);
        nop_step(1'b1, 1'b1);
        nop_step(1'b0, 1'b0);
        // T5 cold write 0x6058: row 3, bank 2, col 5 -> slow-path STERM
        add(1'b1, 32'h0000_6058, 1'b0, 1'b0, mk(C_ACT, P_ACT, 13'h3, 2'd2, 1'b0));
        nop_step(1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 1'b1, mk(C_CLR, P_WR, 13'h5, 2'd2, 1'b1));
        nop_step(1'b0, 1'b0);
        // T6 A[31]=1 is outside the window: ignored
        add(1'b1, 32'h8000_2004, 1'b1, 1'b0, mk(C_NOP, P_NOP, 13'h0, 2'd0, 1'b0));
        nop_step(1'b1, 1'b0);
        nop_step(1'b0, 1'b0);
        // T7 aborted read 0x800C (row 4, bank 3): SEL drops after ACTIVATE
        add(1'b1, 32'h0000_800C, 1'b1, 1'b1, mk(C_ACT, P_ACT, 13'h4, 2'd3, 1'b0));
        nop_step(1'b0, 1'b0);
        nop_step(1'b0, 1'b0);
        nop_step(1'b0, 1'b0);
        // T8 same address: the aborted ACTIVATE left the row open -> hit
        add(1'b1, 32'h0000_800C, 1'b1, 1'b0, mk(C_NOP, P_RD, 13'h0, 2'd3, 1'b0));
        nop_step(1'b0, 1'b0);
        nop_step(1'b1, 1'b1);
        nop_step(1'b0, 1'b0);

        // reset + init
        RESET = 1'b1;
        tick();
        check_obs("reset", mk(C_RST, P_NOP, 13'h0, 2'd0, 1'b0));
        check_int("reset_state", int'(dbg), int'(S_INIT_WAIT));
        RESET = 1'b0;
        bad = 0;
        for (int i = 1; i < INIT_W; i++) begin
            tick();
            if (cmd !== C_RST) bad++;
        end
        check_int("init_wait_cmd000_errors", bad, 0);
        tick();
        check_obs("init_pall", mk(C_PALL, P_PRE, 13'h400, 2'd0, 1'b0));

        nref = 0; last = cyc; bad = 0; others = 0; mrs_seen = 0; mrs_ra = -1; mrs_gap = 0;
        for (int i = 0; i < 120 && mrs_seen == 0; i++) begin
            tick();
            gap = cyc - last;
            if ({ncs, nras, ncas, nwe_o} == P_REF) begin
                if (gap < ((nref == 0) ? 2 : 7)) bad++;
                nref++;
                last = cyc;
            end else if ({ncs, nras, ncas, nwe_o} == P_MRS) begin
                mrs_seen = 1; mrs_ra = int'(ra); mrs_gap = gap;
            end else if ({ncs, nras, ncas, nwe_o} != P_NOP) begin
                others++;
            end
        end
        check_int("init_refresh_count", nref, 8);
        check_int("init_refresh_spacing_errors", bad, 0);
        check_int("init_other_cmds", others, 0);
        check_int("init_mrs_seen", mrs_seen, 1);
        check_int("init_mrs_ra", mrs_ra, 32'h020);
        check_int("init_mrs_after_trfc", (mrs_gap >= 7) ? 1 : 0, 1);

        for (int i = 0; i < 20 && dbg != S_IDLE; i++) tick();
        check_int("idle_reached", (dbg == S_IDLE) ? 1 : 0, 1);
        idle0 = cyc;

        // table-driven access steps
        foreach (steps[i]) begin
            if (steps[i].start) begin
                addr = steps[i].a;
                nwe  = steps[i].w_n;
                sel  = 1'b1;
            end
            tick();
            check_obs($sformatf("step%0d", i), steps[i].exp);
            if (steps[i].drop) sel = 1'b0;
        end

        // refresh collision: SEL rises in the cycle the REFI counter hits 0
        target = idle0 + REFI_T - 1;
        while (cyc < target) tick();
        check_int("collision_cycle", cyc, target);
        addr = 32'h0000_2004; nwe = 1'b1; sel = 1'b1;
        tick();
        check_obs("ref_pall", mk(C_PALL, P_PRE, 13'h400, 2'd0, 1'b0));
        tick();
        check_obs("ref_trp_nop", mk(C_NOP, P_NOP, 13'h0, 2'd0, 1'b0));
        tick();
        check_obs("ref_refresh", mk(C_NOP, P_REF, 13'h0, 2'd0, 1'b0));
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample() !== mk(C_NOP, P_NOP, 13'h0, 2'd0, 1'b0)) bad++;
        end
        check_int("ref_trfc_nop_errors", bad, 0);
        tick();
        check_obs("ref_clear_spec", mk(C_CLR, P_NOP, 13'h0, 2'd0, 1'b0));
        tick();
        check_obs("ref_reactivate", mk(C_ACT, P_ACT, 13'h1, 2'd1, 1'b0));

        // reset in the middle of the tRCD wait
        RESET = 1'b1;
        tick();
        check_obs("midreset", mk(C_RST, P_NOP, 13'h0, 2'd0, 1'b0));
        check_int("midreset_state", int'(dbg), int'(S_INIT_WAIT));
        RESET = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample() !== mk(C_RST, P_NOP, 13'h0, 2'd0, 1'b0)) bad++;
        end
        check_int("midreset_reinit_errors", bad, 0);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_seq.md
Name: sdram_cmd_seq

Overview:
- SDRAM command sequencer for the main-RAM window (A[31]=0).
- Turns CPU access strobes into SDRAM commands, and generates STERM for accesses the fast-path terminator does not cover.
- Emits the 3-bit CMD tracking bus that the downstream bank/row terminator consumes.
- Open-row policy: rows stay open until a row conflict or a refresh.

Parameters:
- tRP, 2: precharge-to-activate delay, in CLK cycles.
- tRCD, 2: activate-to-read/write delay, in CLK cycles.
- CL, 2: CAS latency, either 2 or 3.
- tRFC, 7: auto-refresh-to-next-command delay, in cycles.
- REFI, 780: refresh interval, in cycles.
- INIT_WAIT, 5000: power-up idle before initialisation starts, in cycles.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  in  30  CPU address A[31:2]. Row=A[25:13], Col=A[12:4], Bank=A[3:2].
- nWE  in  1  CPU write strobe, active low.
- SEL  in  1  RAM access strobe, held until termination.
- STERMout  out  1  slow-path termination, fed to the terminator's STERMin.
- CMD  out  3  tracking code. 000 reset, 001 activate, 010 row precharge, 011 precharge all, 100 NOP, 110 clear speculation. 101 and 111 are never driven.
- nRCS, nRRAS, nRCAS, nRWE  out  1 each  SDRAM command pins.
- RBA  out  2  SDRAM bank address.
- RA  out  13  SDRAM address.

Behaviour:
- Reset values (applied on every RESET-high edge, mid-operation included):
  - CMD=000, STERMout=0, SDRAM command=NOP, RA=0, RBA=0.
  - Shadow BankActive=0, init counter cleared, state=INIT_WAIT.
  - The next command is issued only after the full init sequence.
- Internal shadow: a per-bank open flag and row register. It must track exactly what the terminator tracks: update on CMD 001/010/011/000 only.
- Init sequence:
  - INIT_WAIT: INIT_WAIT cycles, CMD=000.
  - INIT_PALL: PRECHARGE ALL with RA[10]=1, CMD=011, then wait tRP.
  - INIT_REF: 8 × (REFRESH, wait tRFC).
  - INIT_MRS: MODE REGISTER SET with RA = {burst 1, sequential, CL, write burst single}.
  - Then IDLE.
- IDLE decode, acting only when SEL=1 and A[31]=0, with SEL first seen this cycle or still unserved:
  - Read hit (bank open, row match): READ with RA=Col, RBA=Bank. Wait CL cycles, then STERMout=1 for exactly one cycle.
  - Write hit: WRITE issued in the same cycle SEL is first sampled; CMD=110 that cycle. STERMout stays 0, because the terminator supplies termination.
  - Bank closed: ACTIVATE with RA=Row, RBA=Bank, CMD=001. Wait tRCD, then READ or WRITE as for a hit.
  - Row conflict: PRECHARGE with RA[10]=0, CMD=010. Wait tRP, then the closed-bank path.
  - Slow-path termination: STERMout=1 for exactly one cycle for every read, and for every write that needed an activate. For such writes it pulses in the cycle WRITE is issued, and CMD=110 in that same cycle.
- Refresh:
  - A REFI down-counter sets refresh-pending when it reaches 0, then reloads.
  - Pending refresh is serviced only from IDLE with no access in flight: PRECHARGE ALL with CMD=011, wait tRP; REFRESH, wait tRFC; CMD=110; back to IDLE.
  - Pending refresh takes priority over a new SEL arriving in the same cycle.
  - If a second REFI expiry occurs while a refresh is still pending, the flag stays set; no count is kept.
- CMD is 100 in every cycle not listed above.
- CMD 001/010 are driven only while A holds the access's address, because the terminator samples A with CMD.
- SEL dropping before termination (aborted cycle): finish the current SDRAM command and its timing wait, suppress STERMout, return to IDLE.
- After termination, the sequencer waits for SEL to deassert before accepting a new access.
- All timing waits use one shared 4-bit down-counter. Widths are sized so that tRFC ≤ 15.

Decomposition:
- Shared package sdram_pkg holds:
  - CMD code constants, shared with the terminator.
  - SDRAM command encodings {nCS,nRAS,nCAS,nWE}.
  - The mode-register value.
  - The address-slice constants for row, column and bank.
- Natural sub-module: sdram_refresh_timer (REFI counter plus pending flag, with a clear input).

Test Plan:
- Reset + init: RESET 1 cycle, then run. Required sequence: INIT_WAIT cycles of CMD=000, then PALL with CMD=011, 8 REFRESH spaced ≥ tRFC, then MRS with RA=0x020 (CL=2), then IDLE.
- Cold read: SEL, nWE=1, A=0x0000_2004 (row 1, bank 1). Required: ACTIVATE with RBA=1, RA=1, CMD=001; READ at +2 cycles with RA=0; STERMout pulse at READ+2.
- Write hit: after the cold read, write A=0x0000_2014. Required: WRITE issued in the first SEL cycle, CMD=110, no STERMout.
- Row conflict: read A=0x0000_4004 (row 2, bank 1). Required: PRECHARGE with CMD=010 and RBA=1; ACTIVATE at +2 with RA=2; shadow Bank1Row=2.
- Refresh collision: force REFI expiry in the same cycle SEL rises. Required: PALL/REFRESH completes first, then ACTIVATE is reissued for the access. Also assert RESET mid-tRCD wait: all outputs return to reset values on the next edge.
